// File: rtl/mem_stage_pkg.sv
// Shared encodings and lane helpers for the MEM pipeline stage.
package mem_stage_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic {IDLE, BUSY} state_t;

   function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr);
      case (size)
         SZ_BYTE: is_aligned = 1'b1;
         SZ_HALF: is_aligned = ~addr[0];
         default: is_aligned = (addr == 2'b00);
      endcase
   endfunction

   function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] addr);
      case (size)
         SZ_BYTE: byte_enable = 4'b0001 << addr;
         SZ_HALF: byte_enable = addr[1] ? 4'b1100 : 4'b0011;
         default: byte_enable = 4'b1111;
      endcase
   endfunction

   // Replicate the store data across lanes so the byte enables alone pick the target lane.
   function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
      case (size)
         SZ_BYTE: store_lanes = {4{data[7:0]}};
         SZ_HALF: store_lanes = {2{data[15:0]}};
         default: store_lanes = data;
      endcase
   endfunction

   function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] addr, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{addr, 3'b000} +: 8];
      h = addr[1] ? word[31:16] : word[15:0];
      case (size)
         SZ_BYTE: load_extract = uns ? {24'b0, b} : {{24{b[7]}}, b};
         SZ_HALF: load_extract = uns ? {16'b0, h} : {{16{h[15]}}, h};
         default: load_extract = word;
      endcase
   endfunction

endpackage

// File: rtl/data_mem_be.sv
// Word-organised data memory with per-byte write enables and asynchronous read.
module data_mem_be #(
   parameter int DEPTH_WORDS = 256,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage_lat.sv
// MIPS MEM stage: branch resolution, byte/half/word loads and stores with a
// configurable access latency, upstream stall, and MEM/WB output registers.
module mem_stage_lat
   import mem_stage_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int DEPTH_WORDS = 256,
   parameter int MEM_LATENCY = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [31:0]       target,
   input  logic              zero,
   input  logic              branch,
   input  logic              branch_ne,
   input  logic [31:0]       result,
   input  logic [DATA_W-1:0] reg_data2,
   input  logic [4:0]        reg_desti,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [1:0]        mem_size,
   input  logic              mem_unsigned,
   input  logic              reg_write_in,
   input  logic              mem_to_reg_in,
   output logic              pc_src,
   output logic [31:0]       pc_target,
   output logic              stall,
   output logic              out_valid,
   output logic [DATA_W-1:0] wb_read_data,
   output logic [31:0]       wb_result,
   output logic [4:0]        wb_reg_desti,
   output logic              wb_reg_write,
   output logic              wb_mem_to_reg,
   output logic              misalign
);

   localparam int AW    = $clog2(DEPTH_WORDS);
   localparam bit MULTI = (MEM_LATENCY > 1);
   localparam int CNT_W = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY - 1) : 1;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             mem_op, aligned, misaligned_op, commit, pass;
   logic [31:0]      rd_word;
   logic             unused_addr_bits;

   assign mem_op        = in_valid & (mem_read | mem_write);
   assign aligned       = is_aligned(mem_size, result[1:0]);
   assign misaligned_op = mem_op & ~aligned;
   assign pass          = (state == IDLE) && in_valid && !(mem_op && aligned);
   assign commit        = MULTI ? (state == BUSY && cnt == '0)
                                : (state == IDLE && mem_op && aligned);

   assign pc_src           = in_valid & (state == IDLE) & branch & (zero ^ branch_ne);
   assign pc_target        = target;
   assign unused_addr_bits = ^{result[31:AW+2]};

   // Gating the write with reset drops an access that is aborted on its commit edge.
   data_mem_be #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_mem (
      .clk   (clk),
      .we    (commit & mem_write & ~reset),
      .be    (byte_enable(mem_size, result[1:0])),
      .addr  (result[AW+1:2]),
      .wdata (store_lanes(mem_size, 32'(reg_data2))),
      .rdata (rd_word)
   );

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      stall     = 1'b0;
      case (state)
         IDLE: begin
            if (mem_op && aligned && MULTI) begin
               stall     = 1'b1;
               state_nxt = BUSY;
               cnt_nxt   = CNT_W'(MEM_LATENCY - 2);
            end
         end
         BUSY: begin
            stall = (cnt != '0);
            if (cnt == '0) state_nxt = IDLE;
            else           cnt_nxt   = cnt - 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Pulses default low; the WB payload only updates when an instruction leaves the stage.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         out_valid     <= 1'b0;
         misalign      <= 1'b0;
         wb_read_data  <= '0;
         wb_result     <= '0;
         wb_reg_desti  <= '0;
         wb_reg_write  <= 1'b0;
         wb_mem_to_reg <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         out_valid    <= 1'b0;
         misalign     <= 1'b0;
         wb_reg_write <= 1'b0;
         if (commit || pass) begin
            out_valid     <= 1'b1;
            misalign      <= misaligned_op;
            wb_result     <= result;
            wb_reg_desti  <= reg_desti;
            wb_mem_to_reg <= mem_to_reg_in;
            wb_reg_write  <= reg_write_in & ~misaligned_op;
            wb_read_data  <= (commit && mem_read)
                             ? DATA_W'(load_extract(rd_word, mem_size, result[1:0], mem_unsigned))
                             : '0;
         end
      end
   end

endmodule

// File: doc/mem_stage_lat.md
Name: mem_stage_lat

Overview:
Parametrised MIPS MEM pipeline stage.
- Resolves branches (beq/bne) and drives PC select.
- Performs byte, half and word loads and stores into a byte-enabled data memory with a configurable access latency.
- Stalls upstream while an access is in flight.
- Registers the MEM/WB pipeline outputs.

Parameters:
DATA_W, 32, data/register width (fixed 32 for MIPS-I; parameter kept for lane math)
DEPTH_WORDS, 256, data memory depth in words (power of 2)
MEM_LATENCY, 2, total cycles a load/store occupies the stage (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_valid  in  1  EX/MEM holds a valid instruction
target  in  32  branch target
zero  in  1  ALU zero flag
branch  in  1  branch instruction
branch_ne  in  1  1=bne, 0=beq
result  in  32  ALU result / byte address
reg_data2  in  DATA_W  store data
reg_desti  in  5  destination register
mem_read  in  1  load
mem_write  in  1  store
mem_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
mem_unsigned  in  1  zero-extend loads
reg_write_in  in  1  WB write enable
mem_to_reg_in  in  1  WB source select
pc_src  out  1  take branch
pc_target  out  32  = target
stall  out  1  freeze IF/ID/EX and EX/MEM register
out_valid  out  1  MEM/WB valid
wb_read_data  out  DATA_W  extended load data
wb_result  out  32  registered result
wb_reg_desti  out  5  registered destination
wb_reg_write  out  1  registered reg write
wb_mem_to_reg  out  1  registered mem_to_reg
misalign  out  1  one-cycle misaligned-access flag, aligned with out_valid

Behaviour:
- Reset (sync, high): FSM->IDLE, counter 0, all registered outputs 0. Memory contents are not cleared.
- An in-flight access is aborted at reset: no write is committed, and no out_valid is produced for it.
- mem_op = in_valid & (mem_read | mem_write).
- Alignment: half needs addr[0]=0; word needs addr[1:0]=0.
- Indexing: word index = result[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored (address wraps).
- pc_src = in_valid & state==IDLE & branch & (zero ^ branch_ne). It is combinational. pc_target = target.
- FSM states: IDLE, BUSY.
  - IDLE, non-mem op or misaligned op: stall=0. Pass-through to WB regs at the next edge.
  - IDLE, aligned mem_op, MEM_LATENCY==1: stall=0. Access commits at this edge.
  - IDLE, aligned mem_op, MEM_LATENCY>1: stall=1. Go to BUSY, cnt=MEM_LATENCY-2.
  - BUSY: stall=(cnt!=0); cnt decrements each cycle. At cnt==0 the access commits at the edge and the FSM returns to IDLE.
  - Upstream holds all inputs stable while stall=1.
  - Net effect: stall is high for MEM_LATENCY-1 cycles, and the instruction occupies the stage for MEM_LATENCY cycles.
- Commit edge:
  - Store: write byte lanes only. Byte lane = addr[1:0] with data reg_data2[7:0]. Half lanes {addr[1],0} with data [15:0]. Word writes all lanes.
  - Load: select the addressed lane, sign- or zero-extend per mem_unsigned, register into wb_read_data.
  - A load immediately following a store to the same word sees the new data.
  - WB regs load result, reg_desti, reg_write_in, mem_to_reg_in. out_valid=1.
- Misaligned mem_op:
  - No write is performed; wb_read_data=0.
  - wb_reg_write forced 0; misalign=1; out_valid=1.
  - Single cycle, no stall.
- in_valid=0 in IDLE: out_valid=0 and wb_reg_write=0 next cycle. Other WB regs are don't-care but deterministic (held).
- out_valid and misalign are single-cycle pulses per instruction.

Decomposition:
- Package mem_stage_pkg:
  - mem_size encodings (SZ_BYTE, SZ_HALF, SZ_WORD).
  - FSM state enum (IDLE, BUSY).
  - Function for byte-enable generation.
  - Function for load extract/extend.
- Sub-module data_mem_be:
  - DEPTH_WORDS x 32 array.
  - 4-bit byte-enable synchronous write, asynchronous read.
  - Instantiated once; write enable pulsed only at the commit edge.

Test Plan:
- MEM_LATENCY=2: sw 0xDEADBEEF @0x10 -> stall high 1 cycle; out_valid at edge 2. Then lw @0x10 -> wb_read_data=0xDEADBEEF after 2 cycles.
- sb 0x80 @0x13 onto word 0x11223344 -> word = 0x80223344. lb @0x13 -> 0xFFFFFF80; lbu -> 0x00000080.
- sh 0xBEEF @0x22, then lh @0x22 -> 0xFFFFBEEF. lh @0x21 -> misalign=1, wb_reg_write=0, memory unchanged, no stall.
- beq zero=1 -> pc_src=1. bne zero=1 -> pc_src=0. bne zero=0 -> pc_src=1. in_valid=0 -> pc_src=0.
- MEM_LATENCY=4: sw issued, reset asserted in the 2nd BUSY cycle -> stall=0 and outputs 0 next cycle. Subsequent lw of that word returns the old value.
- MEM_LATENCY=1: back-to-back sw/lw/sw/lw -> stall never asserts. One out_valid per cycle with correct data.
